// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_unit arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic SEND      = 1'b1;
  localparam logic RECV      = 1'b0;
  localparam int   CNT_W_DEF = 16;
endpackage

// File: rtl/uart_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, searching circularly.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;

  // Rotate so bit k of rot is req[(ptr+k) mod N]; lowest set bit wins.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = (IW+1)'(k);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = sum[IW-1:0];
  end

  assign any  = |req;
  assign pick = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one uart_unit byte engine between N requesters,
// with wrapping completion counters for debug.
module uart_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     rors,
  input  logic [N*8-1:0]   txdata,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [7:0]       rdata,
  output logic             busy,
  output logic             uart_go,
  output logic             uart_rors,
  output logic [7:0]       uart_txdata,
  input  logic [7:0]       uart_rxdata,
  input  logic             uart_done,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             go_q, go_d;
  logic             rors_q, rors_d;
  logic [7:0]       txd_q, txd_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;

  logic [N-1:0]     pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    go_d       = 1'b0;
    rors_d     = rors_q;
    txd_d      = txd_q;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ISSUE;
          gnt_d   = pick;
          gidx_d  = pick_idx;
          rors_d  = rors[pick_idx];
          txd_d   = txdata[{pick_idx, 3'b000} +: 8];
          go_d    = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (uart_done) begin
          done_d = gnt_q;
          if (rors_q == RECV) rdata_d = uart_rxdata;
          if (rors_q == SEND) tx_count_d = tx_count_q + CNT_W'(1);
          else                rx_count_d = rx_count_q + CNT_W'(1);
          ptr_d   = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      go_q       <= 1'b0;
      rors_q     <= 1'b0;
      txd_q      <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      go_q       <= go_d;
      rors_q     <= rors_d;
      txd_q      <= txd_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != IDLE);
  assign uart_go     = go_q;
  assign uart_rors   = rors_q;
  assign uart_txdata = txd_q;
  assign tx_count    = tx_count_q;
  assign rx_count    = rx_count_q;
endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: transaction-timestamp reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_arbiter;
  localparam int N     = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req, rors;
  logic [N*8-1:0]   txdata;
  logic [N-1:0]     gnt, done;
  logic [7:0]       rdata, uart_txdata, uart_rxdata;
  logic             busy, uart_go, uart_rors, uart_done;
  logic [CNT_W-1:0] tx_count, rx_count;

  uart_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .rors        (rors),
    .txdata      (txdata),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .busy        (busy),
    .uart_go     (uart_go),
    .uart_rors   (uart_rors),
    .uart_txdata (uart_txdata),
    .uart_rxdata (uart_rxdata),
    .uart_done   (uart_done),
    .tx_count    (tx_count),
    .rx_count    (rx_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one outstanding transaction described by timestamps.
  bit               m_active = 0;
  int               m_g = 0, m_tgrant = 0, m_tdone = -1, m_ptr = 0;
  logic             m_dir = 0;
  logic [7:0]       m_byte = 0, m_rdata = 0;
  logic [CNT_W-1:0] m_tx = 0, m_rx = 0;
  int               last_go = -100;
  logic [N-1:0]     go_log[$];
  logic [N-1:0]     fair_exp [3] = '{3'b001, 3'b010, 3'b001};

  int   stub_cnt = 0, stub_delay = 5;
  bit   spurious = 0, udone_force = 0, rx_fix_en = 0;
  logic [7:0] rx_fix = 0;
  int   hold [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_active = 0; m_ptr = 0; m_dir = 0; m_byte = 0;
      m_rdata = 0; m_tx = 0; m_rx = 0; last_go = -100;
    end else if (!m_active) begin
      if (req != 0) begin
        for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        m_active = 1; m_tgrant = cyc; m_tdone = -1;
        m_dir = rors[m_g]; m_byte = txdata[m_g*8 +: 8];
      end
    end else if (m_tdone < 0) begin
      if (cyc >= m_tgrant + 2 && uart_done) begin
        m_tdone = cyc;
        if (m_dir) m_tx = m_tx + 1'b1;
        else begin m_rx = m_rx + 1'b1; m_rdata = uart_rxdata; end
        m_ptr = (m_g + 1) % N;
      end
    end else if (cyc == m_tdone + 1) begin
      m_active = 0;
    end
  endtask

  task automatic compare();
    logic [N-1:0] eg, ed;
    eg = '0; ed = '0;
    if (m_active) eg[m_g] = 1'b1;
    if (m_active && m_tdone >= 0 && cyc == m_tdone + 1) ed[m_g] = 1'b1;
    chk("gnt", gnt, eg);
    chk("done", done, ed);
    chk("busy", busy, m_active);
    chk("uart_go", uart_go, m_active && cyc == m_tgrant + 1);
    chk("uart_rors", uart_rors, m_dir);
    chk("uart_txdata", uart_txdata, m_byte);
    chk("rdata", rdata, m_rdata);
    chk("tx_count", tx_count, m_tx);
    chk("rx_count", rx_count, m_rx);
    if (uart_go === 1'b1) begin
      if (last_go >= 0) chk("go_gap_ge4", (cyc - last_go) >= 4, 1);
      last_go = cyc;
      go_log.push_back(gnt);
    end
  endtask

  task automatic tick();
    model_update();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic stub_drive();
    uart_done   = 1'b0;
    uart_rxdata = rx_fix_en ? rx_fix : 8'($urandom);
    if (rst) stub_cnt = 0;
    else if (uart_go === 1'b1) stub_cnt = (stub_delay > 0) ? stub_delay : $urandom_range(1, 6);
    else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) uart_done = 1'b1;
    end else if (spurious && $urandom_range(0, 15) == 0) uart_done = 1'b1;
    if (udone_force) uart_done = 1'b1;
  endtask

  task automatic cycle();
    stub_drive();
    tick();
  endtask

  task automatic wait_done(output logic [N-1:0] dv);
    int n = 0;
    while (done == 0 && n < 100) begin cycle(); n++; end
    chk("done_within_bound", n < 100, 1);
    dv = done;
  endtask

  task automatic random_drive();
    rst    = ($urandom_range(0, 299) == 0);
    rors   = N'($urandom);
    txdata = (N*8)'($urandom);
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin req[i] = 1'b0; hold[i] = 1; end
      else if (hold[i] > 0) begin req[i] = 1'b0; hold[i]--; end
      else if (gnt[i]) req[i] = 1'b1;
      else if (req[i]) begin if ($urandom_range(0, 7) == 0) req[i] = 1'b0; end
      else if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
    end
  endtask

  initial begin
    logic [N-1:0] dv;
    for (int i = 0; i < N; i++) hold[i] = 0;
    rst = 1'b1; req = '1; rors = '0; txdata = '0; uart_done = 1'b0; uart_rxdata = '0;

    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_gnt", gnt, 0);
      chk("reset_busy", busy, 0);
      chk("reset_go", uart_go, 0);
      chk("reset_txcnt", tx_count, 0);
    end
    rst = 1'b0; req = '0;
    cycle();
    chk("post_reset_go", uart_go, 0);
    chk("post_reset_busy", busy, 0);

    req = 3'b010; rors = 3'b010; txdata[15:8] = 8'h41;
    cycle();
    chk("send_gnt", gnt, 3'b010);
    chk("send_go", uart_go, 1);
    chk("send_rors", uart_rors, 1);
    chk("send_txdata", uart_txdata, 8'h41);
    wait_done(dv);
    chk("send_done", dv, 3'b010);
    chk("send_txcnt", tx_count, 1);
    req = '0;
    cycle();
    chk("done_one_cycle", done, 0);

    req = 3'b001; rors = 3'b000; rx_fix_en = 1; rx_fix = 8'h5A;
    cycle();
    wait_done(dv);
    chk("recv_done", dv, 3'b001);
    chk("recv_rdata", rdata, 8'h5A);
    chk("recv_rxcnt", rx_count, 1);
    chk("recv_txcnt", tx_count, 1);
    req = '0; rx_fix_en = 0;
    cycle();

    req = 3'b001; rors = 3'b001; txdata[7:0] = 8'h11;
    cycle();
    txdata[7:0] = 8'hFF;
    cycle(); cycle();
    chk("latched_txdata", uart_txdata, 8'h11);
    wait_done(dv);
    req = '0;
    cycle(); cycle();
    udone_force = 1;
    cycle();
    udone_force = 0;
    cycle();
    chk("idle_udone_done", done, 0);
    chk("idle_udone_txcnt", tx_count, 2);
    chk("idle_udone_rxcnt", rx_count, 1);
    chk("rdata_hold", rdata, 8'h5A);

    rst = 1'b1;
    cycle();
    rst = 1'b0; go_log.delete(); req = 3'b011; rors = '1;
    for (int t = 0; t < 3; t++) begin
      wait_done(dv);
      if (t == 2) req = '0;
      else begin
        req = req & ~dv;
        cycle(); cycle();
        req = req | (dv & 3'b011);
      end
    end
    cycle(); cycle();
    chk("fair_count", go_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("fair_order", (i < go_log.size()) ? go_log[i] : '0, fair_exp[i]);

    req = 3'b001; rors = 3'b000; stub_delay = 20;
    cycle(); cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0; req = '0; stub_delay = 5;
    for (int i = 0; i < 25; i++) begin
      cycle();
      chk("abort_no_done", done, 0);
    end
    req = 3'b101; rors = 3'b111;
    cycle();
    chk("ptr_cleared_gnt", gnt, 3'b001);
    wait_done(dv);
    req = '0;
    cycle();

    for (int i = 0; i < 14; i++) begin
      req = 3'b001; rors = 3'b001;
      cycle();
      wait_done(dv);
      req = '0;
      cycle();
    end
    chk("tx_allones", tx_count, 4'hF);
    req = 3'b001;
    cycle();
    wait_done(dv);
    chk("tx_wrap", tx_count, 4'h0);
    req = '0;
    cycle();

    stub_delay = 0; spurious = 1;
    for (int i = 0; i < 8000; i++) begin
      random_drive();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
Shares one uart_unit byte engine between N requesters, for example the core's in/out instructions and the boot loader/debug monitor.
Each requester issues a byte-level send or receive by holding a request. The arbiter grants requesters round-robin, drives the uart_unit go/done handshake, and returns the completion pulse and received byte to the granted requester only.
It also keeps wrapping counts of completed sends and receives for debug.

Parameters:
N, 2, number of requesters (N >= 2; index 0 is highest priority after reset)
CNT_W, 16, width of the tx/rx completion counters

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
req  in  N  per-requester request level; held until that requester's done pulse
rors  in  N  per-requester direction: 1 = send, 0 = receive
txdata  in  N*8  per-requester send byte; requester i uses bits [8i+7:8i]
gnt  out  N  one-hot index of the requester currently being served; 0 when idle
done  out  N  one-cycle completion pulse, driven only to the granted requester
rdata  out  8  last received byte; valid while done[i] is high for a receive
busy  out  1  high whenever state != IDLE
uart_go  out  1  one-cycle start pulse to uart_unit
uart_rors  out  1  latched direction to uart_unit
uart_txdata  out  8  latched send byte to uart_unit
uart_rxdata  in  8  uart_unit received byte
uart_done  in  1  uart_unit one-cycle completion pulse
tx_count  out  CNT_W  completed sends, wrapping
rx_count  out  CNT_W  completed receives, wrapping

Behaviour:
- Reset values: all outputs 0; round-robin pointer ptr = 0; state = IDLE. The system ties uart_unit rstn = ~rst so both blocks reset together.
- FSM states: IDLE, ISSUE, WAIT, RELEASE. All outputs are registered except busy, which decodes state.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, pick the first set bit at or after ptr, searching circularly. Call it g.
  - Latch g into gnt as one-hot, latch rors[g] into uart_rors and txdata[g] into uart_txdata.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: uart_go = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold gnt, uart_rors and uart_txdata.
  - On uart_done = 1: register done[g] <= 1, and if uart_rors = 0 register rdata <= uart_rxdata.
  - Increment tx_count or rx_count according to uart_rors.
  - Set ptr <= (g+1) mod N and go to RELEASE.
- RELEASE:
  - done[g] is high this cycle only.
  - gnt stays valid this cycle and clears on exit. The next state is always IDLE.
- Requester rules:
  - req[i] must be low in the cycle after done[i].
  - rors[i] and txdata[i] need only be valid in the IDLE cycle in which they are granted. Later changes are ignored because the values are latched.
- Latency: a grant in IDLE cycle t gives uart_go at t+1. done follows the cycle after uart_done. The earliest back-to-back re-issue is 3 cycles after uart_done, so uart_unit is back in its IDLE state before the next uart_go.
- Boundary conditions:
  - A req dropped before being granted produces no operation and no done.
  - uart_done outside WAIT is ignored.
  - Counters wrap from all-ones to 0.
  - rdata holds its value until the next receive completes. A send never changes it.
  - A pending receive blocks all other requesters until a byte arrives. This is accepted behaviour; there is no timeout.
  - rst asserted in any state: next cycle is IDLE with gnt, done, uart_go, counters and ptr all cleared, and no done pulse is emitted for the aborted operation.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, ISSUE, WAIT, RELEASE), localparams for the rors encoding (SEND = 1, RECV = 0), default CNT_W.
- Sub-module rr_pick #(N): purely combinational.
  - Inputs: req, ptr. Outputs: one-hot pick, binary index, any.
  - Instantiated once by the arbiter, which keeps all state.

Test Plan:
1. Reset check: hold rst 3 cycles with req = 2'b11 → all outputs 0, busy 0, no uart_go during reset or in the cycle after release.
2. Single send: req[1] = 1, rors[1] = 1, txdata[1] = 8'h41; stub asserts uart_done 5 cycles after uart_go.
   - Expected: gnt = 2'b10, one uart_go with uart_rors = 1, uart_txdata = 8'h41.
   - Then done = 2'b10 for 1 cycle, tx_count = 1.
3. Receive: req[0] = 1, rors[0] = 0; stub returns uart_rxdata = 8'h5A with uart_done → rdata = 8'h5A while done[0] is high, rx_count = 1, tx_count unchanged.
4. Fairness: after reset both requesters hold sends continuously for three transactions → grant order 0, 1, 0. Each uart_go is 1 cycle and no two uart_go pulses are closer than 4 cycles.
5. Stability: change txdata[0] from 8'h11 to 8'hFF during WAIT → uart_txdata stays 8'h11; uart_done pulsed while IDLE → no done, counters unchanged.
6. Abort and wrap:
   - Assert rst during WAIT → IDLE next cycle, done never pulses, ptr = 0.
   - Preload tx_count to all-ones via 2^CNT_W - 1 sends, or via a force → next send wraps it to 0.
